pipeline_hazard_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RISC-V pipeline; sits beside the decoder and pipeline registers.
- Generates per-stage stall/flush enables and EX-operand forwarding selects.
- Runs a wait/timeout state machine for data-memory accesses that do not complete in one cycle.
- Raises a trap when a data-memory access times out.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 44 ++++
 rtl/pipeline_hazard_ctrl_fwd_unit.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding selects,
// stage-control bundle and the RUN-state stall/flush decision.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } hazard_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic wb_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_NONE   = stage_ctrl_t'(7'b0000000);
  localparam stage_ctrl_t CTRL_FREEZE = stage_ctrl_t'(7'b1111001);
  localparam stage_ctrl_t CTRL_REDIR  = stage_ctrl_t'(7'b0000110);
  localparam stage_ctrl_t CTRL_LDUSE  = stage_ctrl_t'(7'b1100010);

  // Priority: pending memory access > EX redirect > load-use bubble.
  function automatic stage_ctrl_t run_ctrl(input logic mem_block,
                                           input logic redirect,
                                           input logic load_use);
    stage_ctrl_t c;
    c = CTRL_NONE;
    if (mem_block)     c = CTRL_FREEZE;
    else if (redirect) c = CTRL_REDIR;
    else if (load_use) c = CTRL_LDUSE;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-operand forwarding select for one source register; MEM result wins over WB, x0 never forwarded.
module pipeline_hazard_ctrl_fwd_unit
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  output logic [1:0]            sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
  assign wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs);

  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: stall/flush enables, forwarding selects and dmem wait/timeout FSM.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 5,
`ifdef HAZARD_PERF_CNT_EN
  parameter int unsigned CNT_W        = 32,
`endif
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_redirect,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_reg_write,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  input  logic                  trap_ack,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  wb_bubble,
  output logic                  mem_kill,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  trap,
  output logic [1:0]            state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]      perf_stall_cycles,
  output logic [CNT_W-1:0]      perf_flushes,
  output logic [CNT_W-1:0]      perf_load_use
`endif
);

  localparam int unsigned WC_W = $clog2(WAIT_TIMEOUT + 1);

  hazard_state_e state;
  hazard_state_e state_next;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] cnt_next;

  stage_ctrl_t ctrl;
  logic        trap_c;
  logic        kill_c;
  logic        load_use;
  logic        mem_block;
  logic [1:0]  fwd_a_raw;
  logic [1:0]  fwd_b_raw;

  assign load_use  = ex_mem_read && (ex_rd != '0) &&
                     ((id_uses_rs1 && (ex_rd == id_rs1)) ||
                      (id_uses_rs2 && (ex_rd == id_rs2)));
  assign mem_block = dmem_req && !dmem_ready;

  pipeline_hazard_ctrl_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs            (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_a_raw)
  );

  pipeline_hazard_ctrl_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs            (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (fwd_b_raw)
  );

  // State and wait counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  // Next state and stage controls; outputs held at zero while reset is asserted
  always_comb begin
    ctrl       = CTRL_NONE;
    trap_c     = 1'b0;
    kill_c     = 1'b0;
    state_next = state;
    cnt_next   = wait_cnt;
    case (state)
      RUN: begin
        ctrl = run_ctrl(mem_block, ex_redirect, load_use);
        if (mem_block) begin
          state_next = MEM_WAIT;
          cnt_next   = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl       = run_ctrl(1'b0, ex_redirect, load_use);
          state_next = RUN;
          cnt_next   = '0;
        end else begin
          ctrl = CTRL_FREEZE;
          if (wait_cnt == WC_W'(WAIT_TIMEOUT)) state_next = TRAP;
          else                                 cnt_next   = wait_cnt + WC_W'(1);
        end
      end
      TRAP: begin
        ctrl   = CTRL_FREEZE;
        trap_c = 1'b1;
        kill_c = 1'b1;
        if (trap_ack) begin
          state_next = RUN;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
    if (rst) begin
      ctrl   = CTRL_NONE;
      trap_c = 1'b0;
      kill_c = 1'b0;
    end
  end

  assign stall_if  = ctrl.stall_if;
  assign stall_id  = ctrl.stall_id;
  assign stall_ex  = ctrl.stall_ex;
  assign stall_mem = ctrl.stall_mem;
  assign flush_id  = ctrl.flush_id;
  assign flush_ex  = ctrl.flush_ex;
  assign wb_bubble = ctrl.wb_bubble;
  assign trap      = trap_c;
  assign mem_kill  = kill_c;
  assign fwd_a     = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b     = rst ? FWD_RF : fwd_b_raw;
  assign state_o   = state;

`ifdef HAZARD_PERF_CNT_EN
  logic lu_taken;
  assign lu_taken = (state == RUN) && !mem_block && !ex_redirect && load_use;

  // Saturating event counters, updated on the edge after the event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_load_use     <= '0;
    end else begin
      if (ctrl.stall_if && !(&perf_stall_cycles)) perf_stall_cycles <= perf_stall_cycles + CNT_W'(1);
      if (ctrl.flush_id && !(&perf_flushes))      perf_flushes      <= perf_flushes + CNT_W'(1);
      if (lu_taken && !(&perf_load_use))          perf_load_use     <= perf_load_use + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (WAIT_TIMEOUT = 4).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect;
  logic          mem_reg_write, wb_reg_write, dmem_req, dmem_ready, trap_ack;
  logic          stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;
  logic          wb_bubble, mem_kill, trap;
  logic [1:0]    fwd_a, fwd_b, state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]   perf_stall_cycles, perf_flushes, perf_load_use;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .trap_ack(trap_ack),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
    .wb_bubble(wb_bubble), .mem_kill(mem_kill),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .trap(trap), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes),
    .perf_load_use(perf_load_use)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, wb_bubble};
  endfunction

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
    mem_reg_write = 1'b0; wb_reg_write = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0; trap_ack = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_ctrl", 32'(ctrl_vec()), 32'h00);
    check("reset_trap", 32'({trap, mem_kill}), 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // forwarding
    ex_rs1 = 5'd5; mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    #1 check("fwd_mem_prio", 32'(fwd_a), 32'h2);
    mem_rd = 5'd0;
    #1 check("fwd_wb", 32'(fwd_a), 32'h1);
    ex_rs1 = 5'd0; wb_rd = 5'd0;
    #1 check("fwd_x0", 32'(fwd_a), 32'h0);
    ex_rs2 = 5'd9; wb_rd = 5'd9; mem_rd = 5'd3;
    #1 check("fwd_b_wb", 32'(fwd_b), 32'h1);
    mem_rd = 5'd9; mem_reg_write = 1'b0;
    #1 check("fwd_b_memoff", 32'(fwd_b), 32'h1);
    idle();

    // load-use
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
    #1 check("lduse", 32'(ctrl_vec()), 32'b1100010);
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #1 check("lduse_once", 32'(ctrl_vec()), 32'h00);
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_uses_rs2 = 1'b0;
    #1 check("lduse_unused", 32'(ctrl_vec()), 32'h00);
    ex_rd = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b1;
    #1 check("lduse_x0", 32'(ctrl_vec()), 32'h00);

    // redirect beats load-use
    ex_rd = 5'd7; id_rs2 = 5'd7; ex_redirect = 1'b1;
    #1 check("prio_redir", 32'(ctrl_vec()), 32'b0000110);
    idle();

    // memory wait: ready low 3 cycles, high in the 4th; redirect arrives while frozen
    tick();
    dmem_req = 1'b1;
    #1 check("mw_c1", 32'({ctrl_vec(), state_o}), {23'd0, 7'b1111001, 2'd0});
    tick();
    ex_redirect = 1'b1;
    #1 check("mw_c2", 32'({ctrl_vec(), state_o}), {23'd0, 7'b1111001, 2'd1});
    tick();
    #1 check("mw_c3", 32'({ctrl_vec(), state_o}), {23'd0, 7'b1111001, 2'd1});
    tick();
    dmem_ready = 1'b1;
    #1 check("mw_release", 32'({ctrl_vec(), state_o}), {23'd0, 7'b0000110, 2'd1});
    tick();
    idle();
    #1 check("mw_back_run", 32'({ctrl_vec(), state_o}), 32'd0);

    // timeout: 5 stall cycles then trap
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("to_stall%0d", i), 32'({stall_mem, wb_bubble, trap, mem_kill}), 32'b1100);
      tick();
    end
    dmem_ready = 1'b1;
    #1 check("to_trap", 32'({trap, mem_kill, state_o}), 32'b1110);
    check("to_trap_ctrl", 32'(ctrl_vec()), 32'b1111001);
    tick();
    #1 check("trap_ignores_ready", 32'({trap, state_o}), 32'b110);
    trap_ack = 1'b1;
    #1 check("trap_ack_cycle", 32'(trap), 32'd1);
    tick();
    idle();
    #1 check("trap_cleared", 32'({trap, mem_kill, state_o}), 32'd0);

    // asynchronous reset in MEM_WAIT
    dmem_req = 1'b1;
    tick();
    #1 check("ar_in_wait", 32'(state_o), 32'd1);
    rst = 1'b1;
    #1 check("ar_state", 32'(state_o), 32'd0);
    check("ar_ctrl", 32'({ctrl_vec(), trap, mem_kill}), 32'd0);
    tick();
    idle();
    rst = 1'b0;
    tick();
    #1 check("ar_after", 32'({ctrl_vec(), state_o}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
